// File: rtl/fetch_queue.sv
// fetch_queue: show-ahead instruction queue between fetch and decode.
// Holds {instr, pc} pairs with valid/ready handshakes on both sides. The head
// entry is presented combinationally; an empty queue presents all zeros so
// the controller decodes a no-op. A redirect flush empties it in one edge.
module fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [ADDR_W:0]    count,
    output logic               full,
    output logic               empty
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];

    logic [ADDR_W-1:0]  wr_ptr_r;
    logic [ADDR_W-1:0]  rd_ptr_r;
    logic [ADDR_W:0]    count_r;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;

    // Status and handshake qualifiers derived purely from registered occupancy.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == {(ADDR_W+1){1'b0}});
        // in_ready never looks at out_ready, so a full queue refuses a push
        // even when decode pops in the same cycle.
        push_s  = in_valid & ~full_s;
        pop_s   = out_ready & ~empty_s;
    end

    // Pointer and occupancy state; flush outranks any concurrent push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + (ADDR_W+1)'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - (ADDR_W+1)'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Entry storage; intentionally not reset, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push_s && !flush && !rst) begin
            instr_mem[wr_ptr_r] <= in_instr;
            pc_mem[wr_ptr_r]    <= in_pc;
        end
    end

    // Output view: head entry when occupied, all zeros (no-op) when empty.
    always_comb begin
        in_ready  = ~full_s;
        out_valid = ~empty_s;
        count     = count_r;
        full      = full_s;
        empty     = empty_s;
        if (empty_s) begin
            out_instr = {INSTR_W{1'b0}};
            out_pc    = {PC_W{1'b0}};
        end else begin
            out_instr = instr_mem[rd_ptr_r];
            out_pc    = pc_mem[rd_ptr_r];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a queue-based reference model checked on every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_fetch_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int passed = 0;

    fetch_queue #(.DEPTH(8), .ADDR_W(3), .INSTR_W(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO contents as a queue of {instr, pc}.
    logic [63:0] model_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            model_q.delete();
        end else begin
            bit do_push, do_pop;
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = out_ready && (model_q.size() > 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({in_instr, in_pc});
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int n;
        logic [63:0] head;
        n = model_q.size();
        head = (n > 0) ? model_q[0] : 64'h0;
        chk("m_count",     {60'h0, count},      64'(n));
        chk("m_full",      {63'h0, full},       64'(n == DEPTH));
        chk("m_empty",     {63'h0, empty},      64'(n == 0));
        chk("m_in_ready",  {63'h0, in_ready},   64'(n != DEPTH));
        chk("m_out_valid", {63'h0, out_valid},  64'(n != 0));
        chk("m_out_instr", {32'h0, out_instr},  {32'h0, head[63:32]});
        chk("m_out_pc",    {32'h0, out_pc},     {32'h0, head[31:0]});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [31:0] pc0);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_pc    = pc0 + 32'(4 * i);
            in_instr = 32'h1000_0000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        // Reset then idle.
        chk("rst_in_ready",  {63'h0, in_ready},  64'h1);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_empty",     {63'h0, empty},     64'h1);
        chk("rst_count",     {60'h0, count},     64'h0);
        chk("rst_out_instr", {32'h0, out_instr}, 64'h0);

        // Single push with 1-cycle latency, then one pop.
        in_valid = 1'b1; in_instr = 32'h00A0_0093; in_pc = 32'h0;
        step();
        in_valid = 1'b0;
        chk("one_valid", {63'h0, out_valid}, 64'h1);
        chk("one_instr", {32'h0, out_instr}, 64'h0000_0000_00A0_0093);
        chk("one_pc",    {32'h0, out_pc},    64'h0);
        chk("one_count", {60'h0, count},     64'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("one_empty", {63'h0, empty}, 64'h1);
        chk("one_count0", {60'h0, count}, 64'h0);

        // Fill to full, hold a ninth offer, then drain in order.
        push_n(8, 32'h0);
        chk("full_flag",  {63'h0, full},     64'h1);
        chk("full_ready", {63'h0, in_ready}, 64'h0);
        chk("full_count", {60'h0, count},    64'h8);
        in_valid = 1'b1; in_pc = 32'h20; in_instr = 32'hDEAD_BEEF;
        step();
        step();
        chk("ninth_count", {60'h0, count}, 64'h8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_pc", {32'h0, out_pc}, 64'(4 * i));
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", {63'h0, empty}, 64'h1);

        // Streaming push+pop across pointer wrap.
        in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h2000_0000;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_pc    = 32'h100 + 32'(4 * (i + 1));
            in_instr = 32'h2000_0000 + 32'(i + 1);
            chk("stream_pc",    {32'h0, out_pc}, 64'(32'h100 + 32'(4 * i)));
            chk("stream_count", {60'h0, count},  64'h1);
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("stream_empty", {63'h0, empty}, 64'h1);

        // Flush with concurrent push and pop.
        push_n(5, 32'h200);
        chk("pre_flush_count", {60'h0, count}, 64'h5);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_pc = 32'h300; in_instr = 32'hCAFE_0001;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", {60'h0, count},     64'h0);
        chk("flush_empty", {63'h0, empty},     64'h1);
        chk("flush_instr", {32'h0, out_instr}, 64'h0);
        chk("flush_ready", {63'h0, in_ready},  64'h1);
        step();
        chk("flush_stays_empty", {60'h0, count}, 64'h0);

        // Asynchronous reset mid-cycle.
        push_n(3, 32'h400);
        chk("pre_rst_count", {60'h0, count}, 64'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", {60'h0, count},     64'h0);
        chk("arst_valid", {63'h0, out_valid}, 64'h0);
        chk("arst_instr", {32'h0, out_instr}, 64'h0);
        chk("arst_ready", {63'h0, in_ready},  64'h1);
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h0000_0013;
        step();
        in_valid = 1'b0;
        chk("post_rst_count", {60'h0, count},     64'h1);
        chk("post_rst_pc",    {32'h0, out_pc},    64'h500);
        chk("post_rst_instr", {32'h0, out_instr}, 64'h13);
        step();
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and the decode/controller stage.
- Buffers fetched {instr, pc} pairs in a show-ahead FIFO with valid/ready handshakes on both sides.
- Decode reads the head entry combinationally.
- Branch-mispredict redirect uses a synchronous flush that empties the queue in one cycle.

Parameters:
- DEPTH, 8: number of entries; must be a power of 2, minimum 2.
- ADDR_W, 3: log2(DEPTH); pointer width.
- INSTR_W, 32: instruction word width.
- PC_W, 32: program counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous queue clear (mispredict/redirect).
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  queue can accept an entry.
- in_instr  input  INSTR_W  fetched instruction word.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_instr  output  INSTR_W  head instruction; feeds the controller instr input.
- out_pc  output  PC_W  head PC.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage: DEPTH-entry array of {instr, pc}. Registers: wr_ptr and rd_ptr (ADDR_W bits, wrap modulo DEPTH), and count (ADDR_W+1 bits).
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0. Storage array is not reset. Outputs during and after reset:
  - in_ready=1, out_valid=0, full=0, empty=1, count=0.
  - out_instr=0, out_pc=0.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- in_ready = !full. It depends only on registered state, never on out_ready. No push is accepted when full, even if a pop occurs in the same cycle.
- out_valid = !empty.
- out_instr/out_pc = storage[rd_ptr] when !empty; forced to all zeros when empty. All zeros decodes in the controller as no-op control (all signals 0).
- push = in_valid & in_ready. On the clock edge: write storage[wr_ptr], then wr_ptr+1.
- pop = out_valid & out_ready. On the clock edge: rd_ptr+1.
- count update per edge: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N (1-cycle latency). There is no same-cycle bypass when empty.
- Upstream must hold in_instr/in_pc/in_valid stable while in_valid & !in_ready. The queue never drops an offered entry silently.
- out_ready while out_valid=0 is ignored; pointers and count do not change.
- Flush (sampled on the edge, highest priority below rst):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Any push or pop in the same cycle is discarded.
  - The cycle after flush: out_valid=0, in_ready=1.
- Wrap-around: pointers roll from DEPTH-1 to 0. full/empty come from count, never from pointer equality alone.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except when count == DEPTH.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, empty=1, count=0, out_instr=0x00000000.
- Push 0x00A00093/pc=0x0 with out_ready=0 → next cycle out_valid=1, out_instr=0x00A00093, out_pc=0x0, count=1. Raise out_ready one cycle → empty=1, count=0.
- Push 8 entries (pc 0x0..0x1C) with out_ready=0 → full=1, in_ready=0, count=8. Ninth in_valid held → not accepted. Pop all 8 → order pc 0x0..0x1C intact.
- Steady streaming with push and pop each cycle for 20 cycles across pointer wrap → count stays at 1, PCs emerge in order with 1-cycle latency, no loss.
- Fill 5 entries, assert flush with in_valid=1 and out_ready=1 in the same cycle → next cycle count=0, empty=1, out_instr=0. The concurrent entry is not stored.
- Fill 3 entries, assert rst asynchronously mid-cycle → outputs return to reset values before the next edge. A following push behaves as on a fresh queue.
